cp_outbuf_rd_sched: RTL

Read-port scheduler for the AES core output buffer (128 entries x 128 bit, synchronous read, 1-cycle latency). It shares the single buffer read port between two requesters:
- a 32-bit host word-read path;
- a drain engine that streams a programmed range of 128-bit entries out as 32-bit words over a valid/ready interface.

It sits between the bus interface and the core output buffer, ahead of the host read data path.

---
 rtl/cp_outbuf_pkg.sv | 17 +
 rtl/cp_outbuf_rr_grant.sv | 29 ++
 rtl/cp_outbuf_rd_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cp_outbuf_pkg.sv
// cp_outbuf_pkg: shared widths, word-select encoding and drain FSM states for the output-buffer read scheduler
package cp_outbuf_pkg;
    localparam int ADDR_W   = 7;
    localparam int LEN_W    = 8;
    localparam int HOST_WIN = 4;

    localparam logic [1:0] WSEL_W0 = 2'd0;
    localparam logic [1:0] WSEL_W1 = 2'd1;
    localparam logic [1:0] WSEL_W2 = 2'd2;
    localparam logic [1:0] WSEL_W3 = 2'd3;

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_SEND, ST_DONE} drainState_t;

    function automatic logic [31:0] wordSlice(input logic [127:0] ent, input logic [1:0] sel);
        return sel == WSEL_W3 ? ent[127:96] : sel == WSEL_W2 ? ent[95:64] : sel == WSEL_W1 ? ent[63:32] : ent[31:0];
    endfunction
endpackage

// File: rtl/cp_outbuf_rr_grant.sv
// cp_outbuf_rr_grant: host-priority arbiter that forces a drain grant after WIN consecutive host wins
module cp_outbuf_rr_grant
    import cp_outbuf_pkg::*;
#(
    parameter int WIN = HOST_WIN
) (
    input  logic iClk,
    input  logic iRsn,
    input  logic iHostReq,
    input  logic iDrainReq,
    output logic oHostGnt,
    output logic oDrainGnt
);
    localparam int CNT_W = $clog2(WIN + 1);

    logic [CNT_W-1:0] hostCnt;

    // host wins contention until its window is used up
    always_comb begin
        oDrainGnt = iDrainReq && (!iHostReq || hostCnt == CNT_W'(WIN));
        oHostGnt  = iHostReq && !oDrainGnt;
    end

    // count host wins only while the drain is kept waiting
    always_ff @(posedge iClk or negedge iRsn)
        if (!iRsn) hostCnt <= '0;
        else if (!iDrainReq || oDrainGnt) hostCnt <= '0;
        else if (oHostGnt && hostCnt != CNT_W'(WIN)) hostCnt <= hostCnt + CNT_W'(1);
endmodule

// File: rtl/cp_outbuf_rd_sched.sv
// cp_outbuf_rd_sched: shares the output-buffer read port between host word reads and the drain stream engine
// Build option CP_RDSCHED_PREFETCH_EN adds a second holding register so consecutive entries stream without bubbles.
module cp_outbuf_rd_sched
    import cp_outbuf_pkg::*;
(
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iHostReq,
    input  logic [8:0]        iHostAddr,
    output logic              oHostAck,
    output logic              oHostRdVld,
    output logic [31:0]       oHostRdDt,
    input  logic              iDrainStart,
    input  logic [ADDR_W-1:0] iDrainBase,
    input  logic [LEN_W-1:0]  iDrainLen,
    output logic              oDrainBusy,
    output logic              oDrainDone,
    output logic [31:0]       oStrmDt,
    output logic              oStrmVld,
    input  logic              iStrmRdy,
    output logic              oRdEn_CpOutBuf,
    output logic [ADDR_W-1:0] oRdAddr_CpOutBuf,
    input  logic [127:0]      iRdDt_CpOutBuf
);
    drainState_t       state;
    logic [ADDR_W-1:0] base, drainAddr;
    logic [LEN_W-1:0]  len, idx, idxNxt;
    logic [1:0]        word, hostSel;
    logic [127:0]      hold;
    logic [31:0]       hostHold;
    logic              hostVld, hostGnt, drainGnt, drainReq, lastEntry;
`ifdef CP_RDSCHED_PREFETCH_EN
    logic [127:0]      pf;
    logic              pfFull, pfPend, lastWord;
`endif

    cp_outbuf_rr_grant #(.WIN(HOST_WIN)) uGrant (
        .iClk      (iClk),
        .iRsn      (iRsn),
        .iHostReq  (iHostReq && iRsn),
        .iDrainReq (drainReq),
        .oHostGnt  (hostGnt),
        .oDrainGnt (drainGnt)
    );

    // drain request qualification, read-port mux and output word slicing
    always_comb begin
        idxNxt    = idx + LEN_W'(1);
        lastEntry = idxNxt == len;
`ifdef CP_RDSCHED_PREFETCH_EN
        lastWord  = state == ST_SEND && iStrmRdy && word == WSEL_W3;
        drainReq  = state == ST_FETCH || (state == ST_SEND && !pfFull && !pfPend && idxNxt < len);
        drainAddr = base + ADDR_W'(state == ST_FETCH ? idx : idxNxt);
`else
        drainReq  = state == ST_FETCH;
        drainAddr = base + ADDR_W'(idx);
`endif
        oHostAck         = hostGnt;
        oRdEn_CpOutBuf   = hostGnt || drainGnt;
        oRdAddr_CpOutBuf = hostGnt ? iHostAddr[8:2] : drainGnt ? drainAddr : '0;
        oHostRdVld       = hostVld;
        oHostRdDt        = hostVld ? wordSlice(iRdDt_CpOutBuf, hostSel) : hostHold;
        oStrmDt          = wordSlice(hold, word);
    end

    // host read pipeline: remember the word select and keep the last returned word
    always_ff @(posedge iClk or negedge iRsn)
        if (!iRsn) begin
            hostVld  <= 1'b0;
            hostSel  <= WSEL_W0;
            hostHold <= '0;
        end else begin
            hostVld <= hostGnt;
            if (hostGnt) hostSel <= iHostAddr[1:0];
            if (hostVld) hostHold <= oHostRdDt;
        end

    // drain FSM: fetch an entry, hold it, stream its four words, repeat for the programmed range
    always_ff @(posedge iClk or negedge iRsn)
        if (!iRsn) begin
            state      <= ST_IDLE;
            base       <= '0;
            len        <= '0;
            idx        <= '0;
            word       <= WSEL_W0;
            hold       <= '0;
            oDrainBusy <= 1'b0;
            oDrainDone <= 1'b0;
            oStrmVld   <= 1'b0;
`ifdef CP_RDSCHED_PREFETCH_EN
            pf         <= '0;
            pfFull     <= 1'b0;
            pfPend     <= 1'b0;
`endif
        end else begin
            oDrainDone <= 1'b0;
            case (state)
                ST_IDLE: if (iDrainStart) begin
                    base       <= iDrainBase;
                    len        <= iDrainLen;
                    idx        <= '0;
                    state      <= iDrainLen == '0 ? ST_DONE : ST_FETCH;
                    oDrainBusy <= iDrainLen != '0;
                    oDrainDone <= iDrainLen == '0;
                end
                ST_FETCH: if (drainGnt) state <= ST_WAIT;
                ST_WAIT: begin
                    hold     <= iRdDt_CpOutBuf;
                    word     <= WSEL_W0;
                    oStrmVld <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: if (iStrmRdy) begin
                    word <= word + 2'd1;
                    if (word == WSEL_W3 && lastEntry) begin
                        state      <= ST_DONE;
                        oStrmVld   <= 1'b0;
                        oDrainBusy <= 1'b0;
                        oDrainDone <= 1'b1;
                    end else if (word == WSEL_W3) begin
                        idx <= idxNxt;
`ifdef CP_RDSCHED_PREFETCH_EN
                        if (pfFull) hold <= pf;
                        else if (pfPend) hold <= iRdDt_CpOutBuf;
                        else begin
                            oStrmVld <= 1'b0;
                            state    <= drainGnt ? ST_WAIT : ST_FETCH;
                        end
`else
                        oStrmVld <= 1'b0;
                        state    <= ST_FETCH;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef CP_RDSCHED_PREFETCH_EN
            pfPend <= state == ST_SEND && drainGnt && !lastWord;
            if (pfPend && !lastWord) begin
                pf     <= iRdDt_CpOutBuf;
                pfFull <= 1'b1;
            end else if (lastWord) pfFull <= 1'b0;
`endif
        end
endmodule
